rs_syndrome_check: RTL and testbench

//  Receive-side companion of rs_encoder for RS(255,247) over GF(2^8). Accepts one
//  255-symbol codeword per frame on a val/sop/eop stream and computes the 8 syndromes.

---
 rtl/rs_gf_pkg.sv | 38 +++
 rtl/rs_synd_cell.sv | 35 +++
 rtl/rs_syndrome_check.sv | 120 ++++++++++++
 tb/tb_rs_syndrome_check.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_gf_pkg.sv
// GF(2^8) constants and arithmetic shared by the RS(255,247) encode/check path.
package rs_gf_pkg;

    localparam int unsigned SYM_W  = 8;
    localparam int unsigned NN     = 255;
    localparam int unsigned KK     = 247;
    localparam int unsigned TWO_T  = NN - KK;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned SYND_W = TWO_T * SYM_W;

    // Low byte of x^8+x^4+x^3+x^2+1; the x^8 term is implied by the shift-out.
    localparam logic [SYM_W-1:0] PRIM_POLY = 8'h1D;

    localparam logic [SYM_W-1:0] ALPHA_POW [TWO_T] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    function automatic logic [SYM_W-1:0] gf_mul(input logic [SYM_W-1:0] a,
                                                input logic [SYM_W-1:0] b);
        logic [SYM_W-1:0] p;
        logic [SYM_W-1:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < int'(SYM_W); i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = x[SYM_W-1] ? ({x[SYM_W-2:0], 1'b0} ^ PRIM_POLY) : {x[SYM_W-2:0], 1'b0};
        end
        return p;
    endfunction

endpackage

// File: rtl/rs_synd_cell.sv
// One syndrome accumulator: Horner evaluation of the received polynomial at ALPHA.
module rs_synd_cell
    import rs_gf_pkg::*;
#(
    parameter logic [SYM_W-1:0] ALPHA = 8'h01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [SYM_W-1:0] din,
    output logic [SYM_W-1:0] s_nxt_c
);

    logic [SYM_W-1:0] s;

    // Next value is exported so the frame result can be captured on the final symbol.
    always_comb begin
        s_nxt_c = s;
        if (load) begin
            s_nxt_c = din;
        end else if (shift) begin
            s_nxt_c = gf_mul(s, ALPHA) ^ din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s <= '0;
        end else begin
            s <= s_nxt_c;
        end
    end

endmodule

// File: rtl/rs_syndrome_check.sv
// RS(255,247) receive syndrome check: 8 syndromes, framing check, message forwarding.
module rs_syndrome_check
    import rs_gf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              din_val,
    input  logic              din_sop,
    input  logic              din_eop,
    input  logic [SYM_W-1:0]  din,
    output logic              dout_val,
    output logic              dout_sop,
    output logic              dout_eop,
    output logic [SYM_W-1:0]  dout,
    output logic              synd_val,
    output logic [SYND_W-1:0] synd,
    output logic              err_det,
    output logic              frame_err
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NN - 1);
    localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(KK - 1);
    localparam logic [CNT_W-1:0] MSG_LEN  = CNT_W'(KK);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              load_c;
    logic              shift_c;
    logic [SYND_W-1:0] synd_nxt_c;

    // Any accepted sop restarts the accumulators, including one that aborts a frame.
    always_comb begin
        load_c  = din_val & din_sop;
        shift_c = (state == ST_RECV) & din_val & ~din_sop;
    end

    for (genvar j = 0; j < TWO_T; j++) begin : g_cell
        rs_synd_cell #(
            .ALPHA (ALPHA_POW[j])
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .load    (load_c),
            .shift   (shift_c),
            .din     (din),
            .s_nxt_c (synd_nxt_c[SYM_W*j +: SYM_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            dout_val  <= 1'b0;
            dout_sop  <= 1'b0;
            dout_eop  <= 1'b0;
            dout      <= '0;
            synd_val  <= 1'b0;
            synd      <= '0;
            err_det   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            synd_val <= 1'b0;
            dout_val <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (din_val && din_sop) begin
                        cnt      <= CNT_W'(1);
                        dout     <= din;
                        dout_val <= 1'b1;
                        dout_sop <= 1'b1;
                        if (din_eop) begin
                            synd_val  <= 1'b1;
                            synd      <= synd_nxt_c;
                            err_det   <= 1'b1;
                            frame_err <= 1'b1;
                        end else begin
                            state <= ST_RECV;
                        end
                    end
                end
                ST_RECV: begin
                    if (din_val && din_sop) begin
                        // Abort report carries no syndrome; the sop symbol opens a new frame.
                        synd_val  <= 1'b1;
                        synd      <= '0;
                        err_det   <= 1'b1;
                        frame_err <= 1'b1;
                        if (din_eop) begin
                            state <= ST_IDLE;
                        end else begin
                            cnt      <= CNT_W'(1);
                            dout     <= din;
                            dout_val <= 1'b1;
                            dout_sop <= 1'b1;
                        end
                    end else if (din_val) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt < MSG_LEN) begin
                            dout     <= din;
                            dout_val <= 1'b1;
                            dout_eop <= (cnt == MSG_LAST);
                        end
                        if (din_eop || (cnt == LAST_IDX)) begin
                            state     <= ST_IDLE;
                            synd_val  <= 1'b1;
                            synd      <= synd_nxt_c;
                            frame_err <= !(din_eop && (cnt == LAST_IDX));
                            err_det   <= (din_eop && (cnt != LAST_IDX)) || (|synd_nxt_c);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_syndrome_check.sv
// Scoreboard bench for rs_syndrome_check: directed RS(255,247) frames, framing faults, reset.
module tb_rs_syndrome_check;

    localparam int NN = 255;
    localparam int KK = 247;

    typedef struct packed {
        logic [63:0] s;
        logic        ed;
        logic        fe;
    } synd_exp_t;

    typedef struct packed {
        logic [7:0] sym;
        logic       sop;
        logic       eop;
    } dout_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        din_val, din_sop, din_eop;
    logic [7:0]  din;
    logic        dout_val, dout_sop, dout_eop;
    logic [7:0]  dout;
    logic        synd_val;
    logic [63:0] synd;
    logic        err_det, frame_err;

    int vectors = 0;
    int miscompares = 0;

    synd_exp_t sq[$];
    dout_exp_t dq[$];

    logic [7:0] exp_t [0:254];
    int         log_t [0:255];
    logic [7:0] gen   [0:8];
    logic [7:0] cw    [0:254];

    always #5 clk = ~clk;

    rs_syndrome_check dut (
        .clk       (clk),
        .rst       (rst),
        .din_val   (din_val),
        .din_sop   (din_sop),
        .din_eop   (din_eop),
        .din       (din),
        .dout_val  (dout_val),
        .dout_sop  (dout_sop),
        .dout_eop  (dout_eop),
        .dout      (dout),
        .synd_val  (synd_val),
        .synd      (synd),
        .err_det   (err_det),
        .frame_err (frame_err)
    );

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1D) : {a[6:0], 1'b0};
    endfunction

    // Log/antilog multiply, independent of the shift-and-reduce form in the design.
    function automatic logic [7:0] fmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return exp_t[(log_t[a] + log_t[b]) % 255];
    endfunction

    // Direct evaluation S_j = sum c_i * alpha^(j*(n-1-i)) over the first n codeword symbols.
    function automatic logic [63:0] eval_synd(input int n);
        logic [63:0] r;
        logic [7:0]  s;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            s = 8'h00;
            for (int i = 0; i < n; i++) begin
                s = s ^ fmul(cw[i], exp_t[(j * (n - 1 - i)) % 255]);
            end
            r[8*j +: 8] = s;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic e, input logic [7:0] d);
        @(posedge clk);
        #1;
        din_val = v;
        din_sop = s;
        din_eop = e;
        din     = d;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic push_synd(input logic [63:0] s, input logic ed, input logic fe);
        sq.push_back('{s: s, ed: ed, fe: fe});
    endtask

    task automatic send_frame(input int n, input bit eop_last, input bit zero,
                              input bit corrupt, input bit gaps);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            d = zero ? 8'h00 : cw[i];
            if (corrupt && i == NN - 1) d = d ^ 8'h5A;
            if (gaps) begin
                while ($urandom_range(0, 99) < 30) drive(1'b0, 1'b0, 1'b0, 8'hEE);
            end
            if (i < KK) dq.push_back('{sym: d, sop: (i == 0), eop: (i == KK - 1)});
            drive(1'b1, (i == 0), (eop_last && i == n - 1), d);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_synd_val"},  64'(synd_val),  64'd0);
        check({tag, "_synd"},      synd,           64'd0);
        check({tag, "_err_det"},   64'(err_det),   64'd0);
        check({tag, "_frame_err"}, 64'(frame_err), 64'd0);
        check({tag, "_dout_val"},  64'(dout_val),  64'd0);
        check({tag, "_dout_sop"},  64'(dout_sop),  64'd0);
        check({tag, "_dout_eop"},  64'(dout_eop),  64'd0);
        check({tag, "_dout"},      64'(dout),      64'd0);
    endtask

    // Monitor: pop and compare whenever the DUT presents a result or a forwarded symbol.
    initial begin
        synd_exp_t se;
        dout_exp_t de;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (synd_val) begin
                    if (sq.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_synd_val: got 1 required 0 at %0t", $time);
                    end else begin
                        se = sq.pop_front();
                        check("synd",      synd,           se.s);
                        check("err_det",   64'(err_det),   64'(se.ed));
                        check("frame_err", 64'(frame_err), 64'(se.fe));
                    end
                end
                if (dout_val) begin
                    if (dq.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_dout_val: got 1 required 0 at %0t", $time);
                    end else begin
                        de = dq.pop_front();
                        check("dout",     64'(dout),     64'(de.sym));
                        check("dout_sop", 64'(dout_sop), 64'(de.sop));
                        check("dout_eop", 64'(dout_eop), 64'(de.eop));
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] r [0:7];
        logic [7:0] fb;

        rst = 1'b1;
        din_val = 1'b0;
        din_sop = 1'b0;
        din_eop = 1'b0;
        din = 8'h00;

        exp_t[0] = 8'h01;
        log_t[0] = 0;
        log_t[1] = 0;
        for (int k = 1; k < 255; k++) begin
            exp_t[k] = xtime(exp_t[k-1]);
            log_t[exp_t[k]] = k;
        end

        // Generator with roots alpha^0..alpha^7, then systematic encode of 247,246..1.
        gen[0] = 8'h01;
        for (int k = 1; k <= 8; k++) gen[k] = 8'h00;
        for (int j = 0; j < 8; j++) begin
            for (int k = 8; k >= 1; k--) gen[k] = gen[k-1] ^ fmul(gen[k], exp_t[j]);
            gen[0] = fmul(gen[0], exp_t[j]);
        end
        for (int k = 0; k < 8; k++) r[k] = 8'h00;
        for (int i = 0; i < KK; i++) begin
            cw[i] = 8'(KK - i);
            fb = cw[i] ^ r[7];
            for (int k = 7; k >= 1; k--) r[k] = r[k-1] ^ fmul(fb, gen[k]);
            r[0] = fmul(fb, gen[0]);
        end
        for (int k = 0; k < 8; k++) cw[KK + k] = r[7 - k];

        @(posedge clk);
        @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // All-zero codeword, then the encoded codeword back-to-back.
        push_synd(64'd0, 1'b0, 1'b0);
        send_frame(NN, 1'b1, 1'b1, 1'b0, 1'b0);
        push_synd(64'd0, 1'b0, 1'b0);
        send_frame(NN, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Clean codeword with input gaps.
        push_synd(64'd0, 1'b0, 1'b0);
        send_frame(NN, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Early eop on symbol 100, then abort at symbol 50, then a full clean frame.
        push_synd(eval_synd(100), 1'b1, 1'b1);
        send_frame(100, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        push_synd(64'd0, 1'b1, 1'b1);
        send_frame(50, 1'b0, 1'b0, 1'b0, 1'b0);
        push_synd(64'd0, 1'b0, 1'b0);
        send_frame(NN, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Error on the degree-0 coefficient shows up identically in every syndrome.
        push_synd({8{8'h5A}}, 1'b1, 1'b0);
        send_frame(NN, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2);
        push_synd({8{8'h5A}}, 1'b1, 1'b0);
        send_frame(NN, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Reset after symbol 119 of a frame: outputs clear at once, no result for it.
        send_frame(120, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_synd(64'd0, 1'b0, 1'b0);
        send_frame(NN, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(6);

        check("synd_queue_left", 64'(sq.size()), 64'd0);
        check("dout_queue_left", 64'(dq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
